// File: rtl/median_pkg.sv
// rtl/median_pkg.sv - shared state encoding and window constants for the median filter path
package median_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam int WIN_N    = 9;
  localparam int WIN_LAST = 8;
  localparam int K_BITS   = $clog2(WIN_N);

endpackage

// File: rtl/median_line_buffer.sv
// rtl/median_line_buffer.sv - read-before-write line store holding {LB2, LB1} per column
module median_line_buffer
  import median_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 720,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            CLK,
  input  logic            we,
  input  logic [AW-1:0]   addr,
  input  logic [2*W-1:0]  wdata,
  output logic [2*W-1:0]  rdata
);

  logic [2*W-1:0] mem [DEPTH];

  // Asynchronous read gives the old word in the same cycle the new one is written.
  assign rdata = mem[addr];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/median_window_feeder.sv
// rtl/median_window_feeder.sv - builds 3x3 windows from a raster stream and serialises them to the median
module median_window_feeder
  import median_pkg::*;
#(
  parameter int W        = 8,
  parameter int IMG_W    = 720,
  parameter int ROW_BITS = 11
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [W-1:0]             PIX_IN,
  input  logic                     PIX_VALID,
  input  logic                     PIX_SOF,
  output logic                     PIX_READY,
  output logic [W-1:0]             DI,
  output logic                     DSI,
  input  logic                     DSO,
  output logic [$clog2(IMG_W)-1:0] WIN_X,
  output logic [ROW_BITS-1:0]      WIN_Y,
  output logic                     ERR
);

  localparam int                CW       = $clog2(IMG_W);
  localparam logic [CW-1:0]     COL_LAST = CW'(IMG_W - 1);
  localparam logic [K_BITS-1:0] K_LAST   = K_BITS'(WIN_LAST);

  state_t              state;
  logic [CW-1:0]       col;
  logic [CW-1:0]       c_eff;
  logic [ROW_BITS-1:0] row;
  logic [ROW_BITS-1:0] r_eff;
  logic [K_BITS-1:0]   k;
  logic [W-1:0]        win      [WIN_N];
  logic [W-1:0]        win_next [WIN_N];
  logic [2*W-1:0]      lb_rd;
  logic [2*W-1:0]      lb_wr;
  logic                xfer;
  logic                issue;

  assign PIX_READY = (state == IDLE);
  assign xfer      = PIX_VALID & PIX_READY;
  assign c_eff     = PIX_SOF ? '0 : col;
  assign r_eff     = PIX_SOF ? '0 : row;
  assign issue     = (c_eff >= CW'(2)) && (r_eff >= ROW_BITS'(2));
  assign lb_wr     = {lb_rd[W-1:0], PIX_IN};

  median_line_buffer #(
    .W     (W),
    .DEPTH (IMG_W),
    .AW    (CW)
  ) u_lb (
    .CLK   (CLK),
    .we    (xfer),
    .addr  (c_eff),
    .wdata (lb_wr),
    .rdata (lb_rd)
  );

  // Window is row-major, index 3*row+col; the new right column enters top to bottom.
  always_comb begin
    for (int i = 0; i < WIN_N; i++) begin
      win_next[i] = win[i];
    end
    for (int r = 0; r < 3; r++) begin
      win_next[3*r]   = win[3*r+1];
      win_next[3*r+1] = win[3*r+2];
    end
    win_next[2] = lb_rd[2*W-1:W];
    win_next[5] = lb_rd[W-1:0];
    win_next[8] = PIX_IN;
  end

  always_ff @(posedge CLK) begin
    if (xfer) begin
      win <= win_next;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
      k     <= '0;
      DI    <= '0;
      DSI   <= 1'b0;
      WIN_X <= '0;
      WIN_Y <= '0;
      ERR   <= 1'b0;
    end else begin
      if (DSO && (state != WAIT)) begin
        ERR <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (PIX_VALID) begin
            col <= (c_eff == COL_LAST) ? '0 : c_eff + CW'(1);
            if (c_eff == COL_LAST) begin
              row <= (r_eff == '1) ? r_eff : r_eff + ROW_BITS'(1);
            end else begin
              row <= r_eff;
            end
            if (issue) begin
              state <= LOAD;
              k     <= '0;
              DSI   <= 1'b1;
              DI    <= win_next[0];
              WIN_X <= c_eff - CW'(1);
              WIN_Y <= r_eff - ROW_BITS'(1);
            end
          end
        end
        LOAD: begin
          if (k == K_LAST) begin
            state <= WAIT;
            DSI   <= 1'b0;
          end else begin
            k  <= k + K_BITS'(1);
            DI <= win[k + K_BITS'(1)];
          end
        end
        WAIT: begin
          if (DSO) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_median_window_feeder.sv
// tb/tb_median_window_feeder.sv - scoreboard bench for median_window_feeder with a frame-array reference model
module tb_median_window_feeder;

  localparam int W        = 8;
  localparam int IMG_W    = 4;
  localparam int ROW_BITS = 11;
  localparam int XW       = $clog2(IMG_W);

  logic                CLK = 1'b0;
  logic                nRST = 1'b0;
  logic [W-1:0]        PIX_IN = '0;
  logic                PIX_VALID = 1'b0;
  logic                PIX_SOF = 1'b0;
  logic                DSO = 1'b0;
  logic                PIX_READY;
  logic [W-1:0]        DI;
  logic                DSI;
  logic [XW-1:0]       WIN_X;
  logic [ROW_BITS-1:0] WIN_Y;
  logic                ERR;

  always #5 CLK = ~CLK;

  median_window_feeder #(
    .W        (W),
    .IMG_W    (IMG_W),
    .ROW_BITS (ROW_BITS)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .PIX_IN    (PIX_IN),
    .PIX_VALID (PIX_VALID),
    .PIX_SOF   (PIX_SOF),
    .PIX_READY (PIX_READY),
    .DI        (DI),
    .DSI       (DSI),
    .DSO       (DSO),
    .WIN_X     (WIN_X),
    .WIN_Y     (WIN_Y),
    .ERR       (ERR)
  );

  typedef struct packed {
    logic [9*W-1:0]      px;
    logic [XW-1:0]       wx;
    logic [ROW_BITS-1:0] wy;
  } exp_t;

  exp_t         q[$];
  int           n_vec = 0;
  int           n_fail = 0;
  logic [W-1:0] img [0:63][0:IMG_W-1];
  int           mr = 0;
  int           mc = 0;
  bit           mon_en = 1'b1;
  bit           resp_en = 1'b1;
  int           bursts = 0;
  int           mon_cnt = 0;
  logic [9*W-1:0] mon_got = '0;
  logic         prev_dsi = 1'b0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic abort(input string name);
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $fatal(1, "aborted");
  endtask

  // Reference: store the frame as a 2D image and cut each interior 3x3 neighbourhood.
  task automatic model_xfer(input logic [W-1:0] p, input bit sof);
    exp_t e;
    if (sof) begin
      mr = 0;
      mc = 0;
    end
    img[mr % 64][mc] = p;
    if (mr >= 2 && mc >= 2) begin
      for (int dr = 0; dr < 3; dr++)
        for (int dc = 0; dc < 3; dc++)
          e.px[(dr*3+dc)*W +: W] = img[(mr-2+dr) % 64][mc-2+dc];
      e.wx = XW'(mc - 1);
      e.wy = ROW_BITS'(mr - 1);
      q.push_back(e);
    end
    mc++;
    if (mc == IMG_W) begin
      mc = 0;
      mr++;
    end
  endtask

  task automatic send(input logic [W-1:0] p, input bit sof);
    int t = 0;
    @(negedge CLK);
    PIX_IN = p;
    PIX_SOF = sof;
    PIX_VALID = 1'b1;
    while (!PIX_READY && t < 300) begin
      @(negedge CLK);
      t++;
    end
    if (!PIX_READY) abort("send_ready_timeout");
    @(posedge CLK);
    model_xfer(p, sof);
  endtask

  task automatic idle_cycle();
    @(negedge CLK);
    PIX_VALID = 1'b0;
    PIX_SOF = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    idle_cycle();
    while (!(q.size() == 0 && PIX_READY && !DSI) && t < 300) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 300) abort("drain_timeout");
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!mon_en) begin
        mon_cnt = 0;
      end else if (DSI) begin
        if (mon_cnt < 9) mon_got[mon_cnt*W +: W] = DI;
        check("ready_low_in_burst", PIX_READY, 0);
        mon_cnt++;
      end else if (mon_cnt > 0) begin
        check("burst_len", mon_cnt, 9);
        n_vec++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_burst: got window at (%0d,%0d) expected none", WIN_X, WIN_Y);
        end else begin
          e = q.pop_front();
          check("window_px", mon_got, e.px);
          check("win_x", WIN_X, e.wx);
          check("win_y", WIN_Y, e.wy);
        end
        bursts++;
        mon_cnt = 0;
      end
    end
  end

  initial begin : responder
    forever begin
      @(negedge CLK);
      if (resp_en && prev_dsi && !DSI) begin
        repeat (2) @(negedge CLK);
        check("ready_before_dso", PIX_READY, 0);
        DSO = 1'b1;
        @(negedge CLK);
        DSO = 1'b0;
        check("ready_after_dso", PIX_READY, 1);
      end
      prev_dsi = DSI;
    end
  end

  initial begin : stim
    repeat (2) @(negedge CLK);
    check("rst_ready", PIX_READY, 1);
    check("rst_dsi", DSI, 0);
    check("rst_di", DI, 0);
    check("rst_err", ERR, 0);
    check("rst_winx", WIN_X, 0);
    check("rst_winy", WIN_Y, 0);
    nRST = 1'b1;

    // Ordered frame 0..15, valid held high back to back
    bursts = 0;
    for (int i = 0; i < 16; i++) send(W'(i), i == 0);
    drain();
    check("frame_bursts", bursts, 4);

    // Partial frame, then mid-frame SOF restarting the counters
    for (int i = 0; i < 7; i++) send(W'($urandom), i == 0);
    bursts = 0;
    for (int i = 0; i < 16; i++) send(W'($urandom), i == 0);
    drain();
    check("sof_restart_bursts", bursts, 4);

    for (int f = 0; f < 30; f++) begin
      int len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        send(W'($urandom), i == 0);
        if ($urandom_range(0, 3) == 0) idle_cycle();
      end
    end
    drain();

    check("err_before_stray", ERR, 0);
    @(negedge CLK);
    DSO = 1'b1;
    @(negedge CLK);
    DSO = 1'b0;
    check("err_set", ERR, 1);
    check("err_ready_unaffected", PIX_READY, 1);
    repeat (3) @(negedge CLK);
    check("err_sticky", ERR, 1);

    // Reset asserted in the middle of a burst
    mon_en = 1'b0;
    resp_en = 1'b0;
    for (int i = 0; i < 11; i++) send(W'(i + 20), i == 0);
    @(negedge CLK);
    PIX_VALID = 1'b0;
    check("dsi_in_load", DSI, 1);
    @(posedge CLK);
    #2 nRST = 1'b0;
    #1;
    check("async_dsi_drop", DSI, 0);
    check("async_ready", PIX_READY, 1);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    check("post_rst_ready", PIX_READY, 1);
    check("post_rst_err", ERR, 0);
    check("post_rst_winx", WIN_X, 0);
    check("post_rst_winy", WIN_Y, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/median_window_feeder.md
Name: median_window_feeder

Overview:
- Upstream stage of the 3x3 median filter. Accepts a raster pixel stream and keeps two line buffers plus a 3x3 window.
- For every interior pixel position it serialises the 9 window pixels onto the median's DI/DSI interface: DSI high for exactly 9 consecutive cycles.
- It then waits for the median's one-cycle DSO pulse before accepting the next pixel.
- Provides the window-centre coordinates for the downstream writer.

Parameters:
- W, 8, pixel width in bits.
- IMG_W, 720, pixels per line; must be >= 3.
- ROW_BITS, 11, width of the row counter.

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- PIX_IN  in  W  input pixel.
- PIX_VALID  in  1  PIX_IN valid.
- PIX_SOF  in  1  qualifies PIX_IN as first pixel of a frame; sampled only with a transfer.
- PIX_READY  out  1  feeder can accept a pixel.
- DI  out  W  window pixel to median.
- DSI  out  1  window pixel strobe to median.
- DSO  in  1  median result strobe (one-cycle pulse).
- WIN_X  out  $clog2(IMG_W)  centre column of the last issued window (c-1).
- WIN_Y  out  ROW_BITS  centre row of the last issued window (r-1).
- ERR  out  1  sticky protocol error.

Behaviour:
- Reset is nRST, asynchronous, active-low; clock is CLK.
- Reset values:
  - state IDLE, PIX_READY=1, DSI=0, DI=0, WIN_X=0, WIN_Y=0, ERR=0.
  - col=0, row=0, issue count k=0.
  - Line-buffer contents undefined; no output depends on them before they are written.
- Transfer: PIX_VALID & PIX_READY at a rising edge.
- PIX_READY = (state==IDLE), registered-state decode. No combinational path from PIX_VALID.
- On each transfer at column c, row r (if PIX_SOF=1, then c=0 and r=0 for this pixel):
  - Read LB1[c] (row r-1) and LB2[c] (row r-2) before writing.
  - Write LB2[c] <= LB1[c] and LB1[c] <= PIX_IN.
  - Shift the window left one column. The new right column is {LB2[c], LB1[c], PIX_IN} for rows top..bottom.
  - Counters:
    - c==IMG_W-1: col <= 0, row <= row+1, saturating at all-ones.
    - otherwise: col <= c+1.
- States and transitions:
  - IDLE:
    - Transfer with c>=2 and r>=2 (post-SOF values): go to LOAD with k=0, latch WIN_X=c-1, WIN_Y=r-1.
    - Any other transfer: stay in IDLE. Border pixels produce no window.
  - LOAD:
    - DSI=1 and DI=window[k] for k=0..8.
    - Order is row-major: top row left..right, then middle row, then bottom row.
    - k increments each cycle. At k==8, the next state is WAIT and DSI=0 from that cycle.
  - WAIT:
    - DSI=0. On DSO=1, go to IDLE; PIX_READY is 1 the following cycle.
- Latency: transfer at edge t → DSI high in cycles t+1..t+9 → WAIT from t+10 → PIX_READY=1 in the cycle after DSO is sampled.
- DI, DSI and WIN_* are registered outputs. DI holds its last value when DSI=0.
- Boundary cases:
  - DSO=1 while in IDLE or LOAD: ignored for state purposes; sets ERR=1. ERR clears only on reset.
  - PIX_SOF while not READY: impossible, since no transfer can occur.
  - SOF mid-frame: counters restart. Line buffers are not cleared, but the r>=2 rule masks stale rows.
  - Rows beyond the saturated row value continue to issue windows.
  - Reset during LOAD or WAIT: DSI drops immediately (asynchronously) and state returns to IDLE. Downstream median is reset by the same nRST.
- Width rules:
  - col compare against IMG_W-1 uses $clog2(IMG_W) bits.
  - WIN_X = c-1 is computed only when c>=2, so it never wraps.

Decomposition:
- Shared package median_pkg:
  - state enum {IDLE, LOAD, WAIT} as logic[1:0].
  - Constant WIN_N=9, also used by the median block's P parameter.
  - Constant WIN_LAST=8.
- One natural sub-module: median_line_buffer.
  - Single-port read-before-write array of IMG_W x 2W bits, storing {LB2, LB1} in one word.
  - Instantiated once; holds no control logic.

Test Plan:
- Reset check, IMG_W=4: nRST low mid-LOAD → DSI=0 at once; after release PIX_READY=1, ERR=0, WIN_X=0.
- Frame ordering, IMG_W=4: stream 16 pixels valued 0..15, SOF on the first, DSO pulsed 3 cycles after each DSI burst.
  - Required: exactly 4 bursts with (WIN_X,WIN_Y) = (1,1), (2,1), (1,2), (2,2).
  - First burst DI sequence: 0,1,2,4,5,6,8,9,10.
- Burst timing: PIX_VALID held high continuously → each DSI burst is exactly 9 cycles; PIX_READY=0 from the burst start until the cycle after DSO; no transfer occurs while PIX_READY=0.
- Border suppression, IMG_W=4: first 10 pixels of a frame → no DSI activity until the transfer of pixel 10 (r=2, c=2).
- Mid-frame SOF: after 7 pixels assert SOF on the next → no window for the next 10 transfers, then WIN_X=1, WIN_Y=1.
- Protocol error: DSO pulse while IDLE → ERR=1 and stays 1; state and PIX_READY are unaffected.
- Integration with the 9-input median, W=8: 3x3 window values {9,1,8,2,7,3,6,4,5} → median DO=5 when DSO=1.
